// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath: instruction and
// branch-condition feedback in, every datapath control line out.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        CON;
  logic        HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
  logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        Read, write, IncPC;
  logic [4:0]  ALUop;
  logic        Run;

  modport master (
    input  IR, CON,
    output HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
    output HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout,
    output Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC, ALUop, Run
  );

  modport slave (
    output IR, CON,
    input  HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
    input  HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC, ALUop, Run
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (F0-F2), decode IR[31:27], then step
// through the per-opcode execute sequence, one control step per clock.
module control_sequencer (
  input  logic                  Clock,
  input  logic                  Reset,
  control_sequencer_if.master   bus
);
  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_F2, S_EX0, S_EX1, S_EX2, S_EX3, S_EX4, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_RTYPE, C_IMM, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP
  } class_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_e     state_q, state_d;
  logic [4:0] op_q, op_d;
  class_e     cls;
  logic [2:0] step;
  logic       unused_ir;

  assign unused_ir = ^bus.IR[26:0];

  function automatic class_e classify(input logic [4:0] op);
    case (op) inside
      5'd0:          return C_LD;
      5'd1:          return C_LDI;
      5'd2:          return C_ST;
      [5'd3:5'd11]:  return C_RTYPE;
      [5'd12:5'd14]: return C_IMM;
      [5'd15:5'd16]: return C_MULDIV;
      [5'd17:5'd18]: return C_UNARY;
      5'd19:         return C_BR;
      5'd20:         return C_JR;
      5'd21:         return C_JAL;
      5'd22:         return C_IN;
      5'd23:         return C_OUT;
      5'd24:         return C_MFHI;
      5'd25:         return C_MFLO;
      default:       return C_NOP;
    endcase
  endfunction

  // Index of the final EX step for each instruction class
  function automatic logic [2:0] last_step(input class_e c);
    case (c)
      C_RTYPE, C_IMM, C_LDI: return 3'd2;
      C_UNARY, C_JAL:        return 3'd1;
      C_MULDIV, C_BR:        return 3'd3;
      C_LD, C_ST:            return 3'd4;
      default:               return 3'd0;
    endcase
  endfunction

  function automatic state_e ex_state(input logic [2:0] s);
    case (s)
      3'd0:    return S_EX0;
      3'd1:    return S_EX1;
      3'd2:    return S_EX2;
      3'd3:    return S_EX3;
      default: return S_EX4;
    endcase
  endfunction

  // State and captured-opcode registers; Reset forces RST asynchronously
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_RST;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state and control-line decode from present state and captured opcode
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cls           = classify(op_q);
    step          = 3'd0;
    bus.HIin      = 1'b0; bus.LOin   = 1'b0; bus.PCin   = 1'b0; bus.MDRin = 1'b0;
    bus.Zin       = 1'b0; bus.Yin    = 1'b0; bus.MARin  = 1'b0; bus.IRin  = 1'b0;
    bus.CONin     = 1'b0; bus.OUTPORTin = 1'b0;
    bus.HIout     = 1'b0; bus.LOout  = 1'b0; bus.ZHIout = 1'b0; bus.ZLOout = 1'b0;
    bus.PCout     = 1'b0; bus.MDRout = 1'b0; bus.INPORTout = 1'b0; bus.Cout = 1'b0;
    bus.Gra       = 1'b0; bus.Grb    = 1'b0; bus.Grc    = 1'b0;
    bus.Rin       = 1'b0; bus.Rout   = 1'b0; bus.BAout  = 1'b0;
    bus.Read      = 1'b0; bus.write  = 1'b0; bus.IncPC  = 1'b0;
    bus.ALUop     = '0;
    bus.Run       = 1'b1;

    case (state_q)
      S_RST: state_d = S_F0;
      S_F0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1;
        state_d = S_F1;
      end
      S_F1: begin
        bus.Read = 1'b1; bus.MDRin = 1'b1; bus.PCin = 1'b1; bus.IncPC = 1'b1;
        state_d = S_F2;
      end
      S_F2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
        if (bus.IR[31:27] == OP_HALT)     state_d = S_HALT;
        else if (bus.IR[31:27] >= OP_NOP) state_d = S_F0;
        else begin
          state_d = S_EX0;
          op_d    = bus.IR[31:27];
        end
      end
      S_HALT: bus.Run = 1'b0;
      default: begin
        case (state_q)
          S_EX1:   step = 3'd1;
          S_EX2:   step = 3'd2;
          S_EX3:   step = 3'd3;
          S_EX4:   step = 3'd4;
          default: step = 3'd0;
        endcase
        state_d = (step >= last_step(cls)) ? S_F0 : ex_state(step + 3'd1);

        case (cls)
          C_RTYPE, C_IMM: begin
            case (step)
              3'd0: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
              3'd1: begin
                if (cls == C_RTYPE) begin bus.Grc = 1'b1; bus.Rout = 1'b1; end
                else bus.Cout = 1'b1;
                bus.Zin = 1'b1; bus.ALUop = op_q;
              end
              default: begin bus.ZLOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            endcase
          end
          C_UNARY: begin
            if (step == 3'd0) begin
              bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.ALUop = op_q;
            end else begin
              bus.ZLOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end
          end
          C_MULDIV: begin
            case (step)
              3'd0: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
              3'd1: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.ALUop = op_q; end
              3'd2: begin bus.ZLOout = 1'b1; bus.LOin = 1'b1; end
              default: begin bus.ZHIout = 1'b1; bus.HIin = 1'b1; end
            endcase
          end
          // ld/ldi/st share the effective-address computation in EX0-EX1
          C_LD, C_LDI, C_ST: begin
            case (step)
              3'd0: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
              3'd1: begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.ALUop = OP_ADD; end
              3'd2: begin
                bus.ZLOout = 1'b1;
                if (cls == C_LDI) begin bus.Gra = 1'b1; bus.Rin = 1'b1; end
                else bus.MARin = 1'b1;
              end
              3'd3: begin
                bus.MDRin = 1'b1;
                if (cls == C_LD) bus.Read = 1'b1;
                else begin bus.Gra = 1'b1; bus.Rout = 1'b1; end
              end
              default: begin
                if (cls == C_LD) begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                else bus.write = 1'b1;
              end
            endcase
          end
          C_BR: begin
            case (step)
              3'd0: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
              3'd1: begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
              3'd2: begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.ALUop = OP_ADD; end
              default: begin bus.ZLOout = 1'b1; bus.PCin = bus.CON; end
            endcase
          end
          C_JR:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          C_JAL: begin
            if (step == 3'd0) begin bus.PCout = 1'b1; bus.Grb = 1'b1; bus.Rin = 1'b1; end
            else begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          end
          C_IN:   begin bus.INPORTout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          C_OUT:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OUTPORTin = 1'b1; end
          C_MFHI: begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          C_MFLO: begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          default: state_d = S_F0;
        endcase
      end
    endcase
  end
endmodule
